// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and the request legality check for the data-memory access unit
package mem_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ = 1'b1;
  typedef struct packed {
    logic we;
    logic [1:0] size;
    logic sgn;
    logic [1:0] lane;
    logic [31:0] wdata;
  } req_t;
  function automatic logic req_err(input logic [1:0] size, input logic [31:0] addr, input int unsigned depth);
    return size == SZ_BAD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) ||
           {2'b00, addr[31:2]} >= depth;
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: little-endian load extraction/extension and sub-word store merge
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask;
  // aligned stores have lane bits zero, so one shift serves byte, half and word
  always_comb begin
    sh = {lane, 3'b000};
    b = 8'(word >> sh);
    h = lane[1] ? word[31:16] : word[15:0];
    ld_data = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} : size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
    mask = size == SZ_BYTE ? 32'hFF << sh : size == SZ_HALF ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFFFF_FFFF;
    st_word = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte-addressed load/store requests into word-memory cycles
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rw_enable,
  output logic        mem_enable,
  input  logic [31:0] mem_data_out
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [1:0] state, nxt;
  logic [CW-1:0] wcnt;
  logic last, bad;
  logic [31:0] ld_data, st_word;
  req_t r;
  lane_align u_lane (
    .word(mem_data_out),
    .lane(r.lane),
    .size(r.size),
    .sgn(r.sgn),
    .wdata(r.wdata),
    .ld_data(ld_data),
    .st_word(st_word)
  );
  // next state; memory phases end when the wait counter reaches its limit
  always_comb begin
    last = wcnt == CW'(WAIT_CYCLES);
    bad = req_err(req_size, req_addr, DEPTH);
    nxt = state == ST_IDLE ? (req_valid ? (bad ? ST_RESP : (req_we && req_size == SZ_WORD) ? ST_WRITE : ST_READ) : ST_IDLE) :
          state == ST_READ ? (last ? (r.we ? ST_WRITE : ST_RESP) : ST_READ) :
          state == ST_WRITE ? (last ? ST_RESP : ST_WRITE) :
          (resp_ready ? ST_IDLE : ST_RESP);
  end
  // all outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      wcnt <= '0;
      r <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      mem_enable <= 1'b0;
      mem_rw_enable <= MEM_READ;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state <= nxt;
      wcnt <= nxt != state ? '0 : last ? wcnt : wcnt + 1'b1;
      req_ready <= nxt == ST_IDLE;
      resp_valid <= nxt == ST_RESP;
      mem_enable <= nxt == ST_READ || nxt == ST_WRITE;
      mem_rw_enable <= nxt == ST_WRITE ? MEM_WRITE : MEM_READ;
      if (state == ST_IDLE && req_valid) begin
        r <= '{we: req_we, size: req_size, sgn: req_signed, lane: req_addr[1:0], wdata: req_wdata};
        mem_address <= {2'b00, req_addr[31:2]};
      end
      if (nxt == ST_WRITE && state != ST_WRITE)
        mem_data_in <= state == ST_IDLE ? req_wdata : st_word;
      if (nxt == ST_RESP && state != ST_RESP) begin
        resp_err <= state == ST_IDLE;
        resp_rdata <= state == ST_READ ? ld_data : '0;
      end
    end
  end
endmodule
